// File: rtl/intc_hwint_if.sv
// Processor-bus register window between the system bridge and intc_hwint.
// The bridge drives the master side; the interrupt controller is the slave.
interface intc_hwint_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output sel, output we, output addr, output wd, input rd);
  modport slave  (input sel, input we, input addr, input wd, output rd);
endinterface

// File: rtl/intc_hwint.sv
// Six-source interrupt controller driving CPU HWInt[7:2]: pending latch, mask, priority id, event counter.
// Define INTC_EDGE_EN to build the MODE register, edge detection and W1C clearing.
module intc_hwint #(
  parameter int          NSRC       = 6,
  parameter logic [5:0]  RESET_MASK = 6'h00
) (
  input  logic               clk,
  input  logic               reset,
  intc_hwint_if.slave        bus,
  input  logic [NSRC-1:0]    irq_src,
  output logic [NSRC-1:0]    HWInt,
  output logic [2:0]         irq_id
);

  logic [NSRC-1:0] src_q, src_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            wr_en;
  logic            unused_wd;

  assign wr_en     = bus.sel & bus.we;
  assign unused_wd = ^bus.wd[31:NSRC];

`ifdef INTC_EDGE_EN
  logic [NSRC-1:0] src_p_q, src_p_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;

  always_comb begin
    src_p_d = src_q;
    mode_d  = mode_q;
    if (wr_en && bus.addr == 2'd2) mode_d = bus.wd[NSRC-1:0];
    w1c  = (wr_en && bus.addr == 2'd1) ? bus.wd[NSRC-1:0] : '0;
    rise = src_q & ~src_p_q;
    // A rising edge in the same cycle as W1C keeps the bit set.
    for (int i = 0; i < NSRC; i++) begin
      pend_d[i] = mode_q[i] ? (rise[i] | (pend_q[i] & ~w1c[i])) : src_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_p_q <= '0;
      mode_q  <= '0;
    end else begin
      src_p_q <= src_p_d;
      mode_q  <= mode_d;
    end
  end
`else
  always_comb begin
    pend_d = src_q;
  end
`endif

  always_comb begin
    src_d  = irq_src;
    mask_d = mask_q;
    if (wr_en && bus.addr == 2'd0) mask_d = bus.wd[NSRC-1:0];
    // Clearing by a STATUS write overrides a coincident increment.
    cnt_d = cnt_q;
    if (wr_en && bus.addr == 2'd3) begin
      cnt_d = '0;
    end else if (|(pend_d & ~pend_q) && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= RESET_MASK[NSRC-1:0];
      cnt_q  <= '0;
    end else begin
      src_q  <= src_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign HWInt = pend_q & mask_q;

  // Lowest asserted index wins; scanning downward leaves it last-assigned.
  always_comb begin
    irq_id = 3'd7;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (HWInt[i]) irq_id = 3'(i);
    end
  end

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (bus.addr)
        2'd0: bus.rd = {{(32-NSRC){1'b0}}, mask_q};
        2'd1: bus.rd = {{(32-NSRC){1'b0}}, pend_q};
`ifdef INTC_EDGE_EN
        2'd2: bus.rd = {{(32-NSRC){1'b0}}, mode_q};
`else
        2'd2: bus.rd = '0;
`endif
        default: bus.rd = {cnt_q, 13'b0, irq_id};
      endcase
    end
  end

endmodule
